// File: rtl/dmem_responder.sv
// Memory-mapped data-side responder: word RAM, LED register, free-running cycle
// counter and a transmit FIFO with sticky overflow, all decoded from one CPU port.
module dmem_responder #(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_in,
  input  logic        MemRW_in,
  output logic [31:0] Data_out,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] LED_out
);

  localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [31:0] LED_ADDR  = 32'hFFFF_0000;
  localparam logic [31:0] CNT_ADDR  = 32'hFFFF_0004;
  localparam logic [31:0] FIFO_ADDR = 32'hFFFF_0008;
  localparam logic [31:0] CLR_ADDR  = 32'hFFFF_000C;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_CNT,
    SEL_FIFO,
    SEL_CLR
  } sel_e;

  logic [31:0]    ram_q [RAM_WORDS];
  logic [31:0]    fifo_q [FIFO_DEPTH];

  logic [15:0]    led_q, led_d;
  logic [31:0]    cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  logic [31:0]    word_addr;
  logic [AW-1:0]  ram_idx;
  sel_e           sel;
  logic           empty, full;
  logic           pop, push_req, push, ram_we;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Byte offset is masked off so every access is a whole word.
  assign word_addr = Addr_in & 32'hFFFF_FFFC;
  assign ram_idx   = word_addr[2 +: AW];

  always_comb begin
    sel = SEL_NONE;
    if (word_addr[31:8] == '0)          sel = SEL_RAM;
    else if (word_addr == LED_ADDR)     sel = SEL_LED;
    else if (word_addr == CNT_ADDR)     sel = SEL_CNT;
    else if (word_addr == FIFO_ADDR)    sel = SEL_FIFO;
    else if (word_addr == CLR_ADDR)     sel = SEL_CLR;
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign tx_valid = !empty;
  assign tx_data  = empty ? '0 : fifo_q[rd_ptr_q];
  assign LED_out  = led_q;

  always_comb begin
    Data_out = '0;
    case (sel)
      SEL_RAM:  Data_out = ram_q[ram_idx];
      SEL_LED:  Data_out = {16'h0000, led_q};
      SEL_CNT:  Data_out = cnt_q;
      SEL_FIFO: Data_out = {29'd0, ovf_q, full, empty};
      SEL_CLR:  Data_out = {{(32 - CW){1'b0}}, count_q};
      default:  Data_out = '0;
    endcase
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
  always_comb begin
    pop      = tx_valid && tx_ready;
    push_req = MemRW_in && (sel == SEL_FIFO);
    push     = push_req && (!full || pop);
    ram_we   = MemRW_in && (sel == SEL_RAM);

    led_d    = led_q;
    cnt_d    = cnt_q + 32'd1;
    ovf_d    = ovf_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (MemRW_in && (sel == SEL_LED)) led_d = Data_in[15:0];
    if (MemRW_in && (sel == SEL_CLR)) ovf_d = 1'b0;
    if (push_req && !push)            ovf_d = 1'b1;

    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      led_q    <= led_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage arrays keep their contents through reset; FIFO output is gated by count.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx]   <= Data_in;
    if (push)   fifo_q[wr_ptr_q] <= Data_in;
  end

endmodule
